// File: rtl/shiftreg_drv_pkg.sv
// Shared types and sizing helpers for the ShiftReg_3d initiator driver.
package shiftreg_drv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    STALL = 2'd2,
    ERR   = 2'd3
  } drv_state_e;

  localparam int DEF_DATA_BIT_WIDTH = 8;
  localparam int DEF_FIFO_DEPTH     = 4;
  localparam int DEF_MAX_INFLIGHT   = 3;
  localparam int DEF_TIMEOUT        = 15;

  // Bits needed to hold the values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/shiftreg_drv_fifo.sv
// Small first-word-fall-through source buffer with registered full/empty flags.
module shiftreg_drv_fifo
  import shiftreg_drv_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_BIT_WIDTH,
  parameter int DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_din,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_dout,
  output logic              o_full,
  output logic              o_empty_next
);

  localparam int AW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     w_count_next;
  logic              r_full;
  logic              r_empty;
  logic              w_wr_en;
  logic              w_rd_en;

  // A full FIFO refuses pushes even when a pop happens in the same cycle.
  assign w_wr_en      = i_push & ~r_full;
  assign w_rd_en      = i_pop & ~r_empty;
  assign w_count_next = r_count + CW'(w_wr_en) - CW'(w_rd_en);

  assign o_full       = r_full;
  assign o_empty_next = (w_count_next == '0);
  assign o_dout       = r_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_en) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_next;
      r_full  <= (w_count_next == DEPTH_C);
      r_empty <= (w_count_next == '0);
    end
  end

endmodule

// File: rtl/shiftreg_3d_driver.sv
// Initiator-side driver for the logphy 3-stage delay line: buffers source words,
// issues them with enable/ack under a credit limit and checks the returns.
module shiftreg_3d_driver
  import shiftreg_drv_pkg::*;
#(
  parameter int DATA_BIT_WIDTH = DEF_DATA_BIT_WIDTH,
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int MAX_INFLIGHT   = DEF_MAX_INFLIGHT,
  parameter int TIMEOUT        = DEF_TIMEOUT
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                src_valid_i,
  output logic                                src_ready_o,
  input  logic [DATA_BIT_WIDTH-1:0]           src_data_i,
  output logic                                sr_enable_o,
  input  logic                                sr_enable_ack_i,
  output logic [DATA_BIT_WIDTH-1:0]           sr_d_o,
  input  logic                                sr_valid_i,
  input  logic [DATA_BIT_WIDTH-1:0]           sr_q_i,
  output logic                                dst_valid_o,
  output logic [DATA_BIT_WIDTH-1:0]           dst_data_o,
  output logic [cnt_width(MAX_INFLIGHT)-1:0]  inflight_o,
  output logic                                err_timeout_o,
  output logic                                err_spurious_o
);

  localparam int IW = cnt_width(MAX_INFLIGHT);
  localparam int TW = cnt_width(TIMEOUT);
  localparam logic [IW-1:0] MAX_IF   = IW'(MAX_INFLIGHT);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  drv_state_e                r_state;
  drv_state_e                w_state_next;
  logic [IW-1:0]             r_inflight;
  logic [IW-1:0]             w_inflight_next;
  logic [TW-1:0]             r_tmo;
  logic                      r_active;
  logic                      r_dst_valid;
  logic [DATA_BIT_WIDTH-1:0] r_dst_data;
  logic                      r_err_timeout;
  logic                      r_err_spurious;
  logic                      w_full;
  logic                      w_empty_next;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_ret_ok;
  logic                      w_ret_bad;
  logic                      w_tmo_hit;
  logic                      w_have;
  logic                      w_credit;
  logic [DATA_BIT_WIDTH-1:0] w_head;

  shiftreg_drv_fifo #(
    .DATA_W (DATA_BIT_WIDTH),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .i_push       (w_push),
    .i_din        (src_data_i),
    .i_pop        (w_pop),
    .o_dout       (w_head),
    .o_full       (w_full),
    .o_empty_next (w_empty_next)
  );

  // r_active keeps ready low while reset is held so every output reads 0 then.
  assign src_ready_o = r_active & ~w_full & (r_state != ERR);
  assign w_push      = src_valid_i & src_ready_o;
  assign w_pop       = (r_state == REQ) & sr_enable_ack_i;
  assign w_ret_ok    = sr_valid_i & (r_inflight != '0);
  assign w_ret_bad   = sr_valid_i & (r_inflight == '0);
  assign w_tmo_hit   = (r_inflight != '0) & ~sr_valid_i & (r_tmo == TMO_LAST);

  assign w_inflight_next = r_inflight + IW'(w_pop) - IW'(w_ret_ok);
  // Decisions look at post-edge occupancy and credits so a same-cycle push or return counts.
  assign w_have   = ~w_empty_next;
  assign w_credit = (w_inflight_next < MAX_IF);

  assign sr_enable_o    = (r_state == REQ);
  assign sr_d_o         = w_head;
  assign dst_valid_o    = r_dst_valid;
  assign dst_data_o     = r_dst_data;
  assign inflight_o     = r_inflight;
  assign err_timeout_o  = r_err_timeout;
  assign err_spurious_o = r_err_spurious;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_have) w_state_next = w_credit ? REQ : STALL;
      end
      REQ: begin
        if (w_pop) begin
          if (!w_have)       w_state_next = IDLE;
          else if (w_credit) w_state_next = REQ;
          else               w_state_next = STALL;
        end
      end
      STALL: begin
        if (w_credit) w_state_next = REQ;
      end
      default: w_state_next = ERR;
    endcase
    if (w_tmo_hit) w_state_next = ERR;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_inflight     <= '0;
      r_tmo          <= '0;
      r_active       <= 1'b0;
      r_dst_valid    <= 1'b0;
      r_dst_data     <= '0;
      r_err_timeout  <= 1'b0;
      r_err_spurious <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_inflight  <= w_inflight_next;
      r_active    <= 1'b1;
      r_dst_valid <= w_ret_ok;
      if (w_ret_ok) r_dst_data <= sr_q_i;
      // Saturating so a stuck transfer cannot wrap the counter.
      if ((r_inflight == '0) || sr_valid_i) r_tmo <= '0;
      else if (r_tmo != TMO_MAX)            r_tmo <= r_tmo + TW'(1);
      if (w_tmo_hit) r_err_timeout  <= 1'b1;
      if (w_ret_bad) r_err_spurious <= 1'b1;
    end
  end

endmodule
